branch_resolution_update_unit: RTL and testbench

//  EX-stage partner of the branch prediction unit. Compares resolved branch/jump outcomes

---
 rtl/branch_resolution_update_unit_if.sv | 57 +++++
 rtl/branch_resolution_update_unit.sv | 144 ++++++++++++++
 tb/tb_branch_resolution_update_unit.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/branch_resolution_update_unit_if.sv
// Bundle between the EX/MEM boundary and the branch resolution unit. It carries the
// resolved outcome, the prediction carried down the pipe, and the BPU update traffic.
interface branch_resolution_update_unit_if #(
  parameter int PHT_IDX_W = 11,
  parameter int CNT_W     = 32
);
  logic                 Stall;
  logic                 IRQ;
  logic                 EX_Valid;
  logic [1:0]           EX_Type;
  logic                 EX_Is_Call;
  logic [31:0]          EX_PC;
  logic                 EX_Actual_Taken;
  logic [31:0]          EX_Actual_Target;
  logic                 EX_Pred_Taken;
  logic [31:0]          EX_Pred_Target;
  logic                 EX_BTB_Hit;
  logic [PHT_IDX_W-1:0] EX_PHT_Index;
  logic [1:0]           EX_PHT_Counter;

  logic [PHT_IDX_W-1:0] PHT_Write_Index;
  logic [1:0]           PHT_Write_Data;
  logic                 PHT_Write_En;
  logic                 GHR_Write_Data;
  logic                 GHR_Write_En;
  logic [31:0]          BTB_Write_Addr;
  logic [31:0]          BTB_Write_Data;
  logic                 BTB_Write_En;
  logic                 RAS_CALL_Inst;
  logic                 RAS_RET_Inst_EX;
  logic [31:0]          RAS_CALL_Inst_nextPC;
  logic                 Branch_Taken__EX_MEM;
  logic                 Flush;
  logic [31:0]          Redirect_PC;
  logic [CNT_W-1:0]     Branch_Count;
  logic [CNT_W-1:0]     Mispredict_Count;

  modport slave (
    input  Stall, IRQ, EX_Valid, EX_Type, EX_Is_Call, EX_PC, EX_Actual_Taken,
           EX_Actual_Target, EX_Pred_Taken, EX_Pred_Target, EX_BTB_Hit,
           EX_PHT_Index, EX_PHT_Counter,
    output PHT_Write_Index, PHT_Write_Data, PHT_Write_En, GHR_Write_Data, GHR_Write_En,
           BTB_Write_Addr, BTB_Write_Data, BTB_Write_En, RAS_CALL_Inst, RAS_RET_Inst_EX,
           RAS_CALL_Inst_nextPC, Branch_Taken__EX_MEM, Flush, Redirect_PC,
           Branch_Count, Mispredict_Count
  );

  modport master (
    output Stall, IRQ, EX_Valid, EX_Type, EX_Is_Call, EX_PC, EX_Actual_Taken,
           EX_Actual_Target, EX_Pred_Taken, EX_Pred_Target, EX_BTB_Hit,
           EX_PHT_Index, EX_PHT_Counter,
    input  PHT_Write_Index, PHT_Write_Data, PHT_Write_En, GHR_Write_Data, GHR_Write_En,
           BTB_Write_Addr, BTB_Write_Data, BTB_Write_En, RAS_CALL_Inst, RAS_RET_Inst_EX,
           RAS_CALL_Inst_nextPC, Branch_Taken__EX_MEM, Flush, Redirect_PC,
           Branch_Count, Mispredict_Count
  );
endinterface

// File: rtl/branch_resolution_update_unit.sv
// Resolves EX-stage control transfers against their prediction. It drives the PHT/GHR/BTB/RAS
// updates and the mispredict flush, then blanks wrong-path instructions for a short window.
module branch_resolution_update_unit #(
  parameter int PHT_IDX_W      = 11,
  parameter int RECOVER_CYCLES = 2,
  parameter int CNT_W          = 32
) (
  input  logic                    CLK,
  input  logic                    RST,
  branch_resolution_update_unit_if.slave bus
);
  typedef enum logic {IDLE, RECOVER} state_t;

  localparam logic [3:0]       LAST_CNT = 4'(RECOVER_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t     state_reg, state_next;
  logic [3:0] cnt_reg, cnt_next;

  logic        accept, is_cond, is_ret, target_diff, mispredict, flush, btb_alloc;
  logic [1:0]  pht_ctr_next;
  logic [31:0] pc_plus4, redirect_next;

  logic [PHT_IDX_W-1:0] pht_index_reg;
  logic [1:0]           pht_data_reg;
  logic                 pht_en_reg, ghr_data_reg, ghr_en_reg;
  logic [31:0]          btb_addr_reg, btb_data_reg;
  logic                 btb_en_reg, ras_call_reg, ras_ret_reg;
  logic [31:0]          ras_next_pc_reg, redirect_reg;
  logic                 taken_reg, flush_reg;
  logic [CNT_W-1:0]     branch_count_reg, mispredict_count_reg;

  always_comb begin
    accept       = bus.EX_Valid & ~bus.Stall & (state_reg == IDLE);
    is_cond      = (bus.EX_Type == 2'b00);
    is_ret       = (bus.EX_Type == 2'b11);
    target_diff  = (bus.EX_Pred_Target != bus.EX_Actual_Target);
    mispredict   = accept & ((bus.EX_Pred_Taken != bus.EX_Actual_Taken) |
                             (bus.EX_Actual_Taken & target_diff));
    // An interrupt owns the redirect, so no flush and no wrong-path window.
    flush        = mispredict & ~bus.IRQ;
    // RET targets come from the RAS; a hit RET never needs its BTB target refreshed.
    btb_alloc    = accept & bus.EX_Actual_Taken & (~bus.EX_BTB_Hit | (~is_ret & target_diff));
    pc_plus4     = bus.EX_PC + 32'd4;
    redirect_next = bus.EX_Actual_Taken ? {bus.EX_Actual_Target[31:1], 1'b0} : pc_plus4;
    if (bus.EX_Actual_Taken)
      pht_ctr_next = (bus.EX_PHT_Counter == 2'b11) ? 2'b11 : bus.EX_PHT_Counter + 2'b01;
    else
      pht_ctr_next = (bus.EX_PHT_Counter == 2'b00) ? 2'b00 : bus.EX_PHT_Counter - 2'b01;
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (flush) begin
          state_next = RECOVER;
          cnt_next   = 4'd0;
        end
      end
      RECOVER: begin
        if (!bus.Stall) begin
          if (cnt_reg == LAST_CNT) state_next = IDLE;
          else                     cnt_next   = cnt_reg + 4'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg <= IDLE;
      cnt_reg   <= 4'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      pht_index_reg        <= '0;
      pht_data_reg         <= 2'b00;
      pht_en_reg           <= 1'b0;
      ghr_data_reg         <= 1'b0;
      ghr_en_reg           <= 1'b0;
      btb_addr_reg         <= 32'd0;
      btb_data_reg         <= 32'd0;
      btb_en_reg           <= 1'b0;
      ras_call_reg         <= 1'b0;
      ras_ret_reg          <= 1'b0;
      ras_next_pc_reg      <= 32'd0;
      redirect_reg         <= 32'd0;
      taken_reg            <= 1'b0;
      flush_reg            <= 1'b0;
      branch_count_reg     <= '0;
      mispredict_count_reg <= '0;
    end else begin
      pht_en_reg   <= accept & is_cond;
      ghr_en_reg   <= accept & is_cond;
      btb_en_reg   <= btb_alloc;
      ras_call_reg <= accept & bus.EX_Is_Call;
      ras_ret_reg  <= accept & is_ret;
      flush_reg    <= flush;
      if (accept & is_cond) begin
        pht_index_reg <= bus.EX_PHT_Index;
        pht_data_reg  <= pht_ctr_next;
        ghr_data_reg  <= bus.EX_Actual_Taken;
      end
      if (btb_alloc) begin
        btb_addr_reg <= bus.EX_PC;
        btb_data_reg <= {bus.EX_Actual_Target[31:2], bus.EX_Type};
      end
      if (accept & bus.EX_Is_Call) ras_next_pc_reg <= pc_plus4;
      if (accept) begin
        taken_reg        <= bus.EX_Actual_Taken;
        branch_count_reg <= branch_count_reg + CNT_ONE;
      end
      if (mispredict) begin
        redirect_reg         <= redirect_next;
        mispredict_count_reg <= mispredict_count_reg + CNT_ONE;
      end
    end
  end

  assign bus.PHT_Write_Index      = pht_index_reg;
  assign bus.PHT_Write_Data       = pht_data_reg;
  assign bus.PHT_Write_En         = pht_en_reg;
  assign bus.GHR_Write_Data       = ghr_data_reg;
  assign bus.GHR_Write_En         = ghr_en_reg;
  assign bus.BTB_Write_Addr       = btb_addr_reg;
  assign bus.BTB_Write_Data       = btb_data_reg;
  assign bus.BTB_Write_En         = btb_en_reg;
  assign bus.RAS_CALL_Inst        = ras_call_reg;
  assign bus.RAS_RET_Inst_EX      = ras_ret_reg;
  assign bus.RAS_CALL_Inst_nextPC = ras_next_pc_reg;
  assign bus.Branch_Taken__EX_MEM = taken_reg;
  assign bus.Flush                = flush_reg;
  assign bus.Redirect_PC          = redirect_reg;
  assign bus.Branch_Count         = branch_count_reg;
  assign bus.Mispredict_Count     = mispredict_count_reg;
endmodule

// File: tb/tb_branch_resolution_update_unit.sv
// Directed bench for branch_resolution_update_unit: an outcome-level model checked every cycle,
// plus literal expectations at the key points of each scenario.
module tb_branch_resolution_update_unit;
  localparam int PHT_IDX_W = 11;
  localparam int REC       = 2;
  localparam int CNT_W     = 32;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  branch_resolution_update_unit_if #(.PHT_IDX_W(PHT_IDX_W), .CNT_W(CNT_W)) bus ();

  branch_resolution_update_unit #(.PHT_IDX_W(PHT_IDX_W), .RECOVER_CYCLES(REC), .CNT_W(CNT_W)) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus.slave)
  );

  int checks = 0;
  int fails  = 0;
  int pin_tag = 0;
  bit started = 0;

  // Expected outputs, derived from the outcome rules
  logic [PHT_IDX_W-1:0] e_pidx;
  logic [1:0]  e_pdata;
  logic        e_pen, e_gdata, e_gen, e_ben, e_call, e_ret, e_taken, e_flush;
  logic [31:0] e_baddr, e_bdata, e_npc, e_redir;
  int unsigned e_bcnt, e_mcnt, prev_bcnt;
  int rec_left;

  always @(posedge CLK) begin : model
    bit acc, mis;
    int c;
    if (RST) begin
      e_pidx = '0; e_pdata = 0; e_pen = 0; e_gdata = 0; e_gen = 0; e_ben = 0;
      e_call = 0; e_ret = 0; e_taken = 0; e_flush = 0;
      e_baddr = 0; e_bdata = 0; e_npc = 0; e_redir = 0;
      e_bcnt = 0; e_mcnt = 0; rec_left = 0; started = 1;
    end else begin
      acc = bus.EX_Valid && !bus.Stall && (rec_left == 0);
      e_pen = 0; e_gen = 0; e_ben = 0; e_call = 0; e_ret = 0; e_flush = 0;
      if (rec_left > 0 && !bus.Stall) rec_left = rec_left - 1;
      if (acc) begin
        e_bcnt  = e_bcnt + 1;
        e_taken = bus.EX_Actual_Taken;
        if (bus.EX_Type == 2'd0) begin
          c = int'(bus.EX_PHT_Counter) + (bus.EX_Actual_Taken ? 1 : -1);
          if (c > 3) c = 3;
          if (c < 0) c = 0;
          e_pen = 1; e_pidx = bus.EX_PHT_Index; e_pdata = 2'(c);
          e_gen = 1; e_gdata = bus.EX_Actual_Taken;
        end
        if (bus.EX_Actual_Taken && (!bus.EX_BTB_Hit ||
            (bus.EX_Type != 2'd3 && bus.EX_Pred_Target != bus.EX_Actual_Target))) begin
          e_ben = 1; e_baddr = bus.EX_PC;
          e_bdata = (bus.EX_Actual_Target & 32'hFFFF_FFFC) | 32'(bus.EX_Type);
        end
        if (bus.EX_Is_Call) begin e_call = 1; e_npc = bus.EX_PC + 32'd4; end
        e_ret = (bus.EX_Type == 2'd3);
        mis = (bus.EX_Pred_Taken != bus.EX_Actual_Taken) ||
              (bus.EX_Actual_Taken && bus.EX_Pred_Target != bus.EX_Actual_Target);
        if (mis) begin
          e_mcnt  = e_mcnt + 1;
          e_redir = bus.EX_Actual_Taken ? (bus.EX_Actual_Target & 32'hFFFF_FFFE) : bus.EX_PC + 32'd4;
          if (!bus.IRQ) begin e_flush = 1; rec_left = REC; end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin : compare
    if (started) begin
      chk("PHT_Write_Index", 64'(bus.PHT_Write_Index), 64'(e_pidx));
      chk("PHT_Write_Data", 64'(bus.PHT_Write_Data), 64'(e_pdata));
      chk("PHT_Write_En", 64'(bus.PHT_Write_En), 64'(e_pen));
      chk("GHR_Write_Data", 64'(bus.GHR_Write_Data), 64'(e_gdata));
      chk("GHR_Write_En", 64'(bus.GHR_Write_En), 64'(e_gen));
      chk("BTB_Write_Addr", 64'(bus.BTB_Write_Addr), 64'(e_baddr));
      chk("BTB_Write_Data", 64'(bus.BTB_Write_Data), 64'(e_bdata));
      chk("BTB_Write_En", 64'(bus.BTB_Write_En), 64'(e_ben));
      chk("RAS_CALL_Inst", 64'(bus.RAS_CALL_Inst), 64'(e_call));
      chk("RAS_RET_Inst_EX", 64'(bus.RAS_RET_Inst_EX), 64'(e_ret));
      chk("RAS_CALL_Inst_nextPC", 64'(bus.RAS_CALL_Inst_nextPC), 64'(e_npc));
      chk("Branch_Taken__EX_MEM", 64'(bus.Branch_Taken__EX_MEM), 64'(e_taken));
      chk("Flush", 64'(bus.Flush), 64'(e_flush));
      chk("Redirect_PC", 64'(bus.Redirect_PC), 64'(e_redir));
      chk("Branch_Count", 64'(bus.Branch_Count), 64'(e_bcnt));
      chk("Mispredict_Count", 64'(bus.Mispredict_Count), 64'(e_mcnt));
      if (e_bcnt != prev_bcnt)
        $display("txn %0d: type=%0d flush=%0b redirect=%h mispredicts=%0d",
                 e_bcnt, dut.bus.EX_Type, bus.Flush, bus.Redirect_PC, bus.Mispredict_Count);
      prev_bcnt = e_bcnt;
      case (pin_tag)
        1: begin
          chk("t1_pht_data", 64'(bus.PHT_Write_Data), 64'h2);
          chk("t1_ghr", 64'(bus.GHR_Write_Data), 64'h1);
          chk("t1_btb_addr", 64'(bus.BTB_Write_Addr), 64'h100);
          chk("t1_btb_data", 64'(bus.BTB_Write_Data), 64'h140);
          chk("t1_flush", 64'(bus.Flush), 64'h1);
          chk("t1_redirect", 64'(bus.Redirect_PC), 64'h140);
          chk("t1_mcnt", 64'(bus.Mispredict_Count), 64'h1);
        end
        2: begin
          chk("t2_pht_data", 64'(bus.PHT_Write_Data), 64'h3);
          chk("t2_btb_en", 64'(bus.BTB_Write_En), 64'h0);
          chk("t2_flush", 64'(bus.Flush), 64'h0);
        end
        3: begin
          chk("t3_btb_data", 64'(bus.BTB_Write_Data), 64'h8B);
          chk("t3_ras_ret", 64'(bus.RAS_RET_Inst_EX), 64'h1);
          chk("t3_flush", 64'(bus.Flush), 64'h1);
          chk("t3_redirect", 64'(bus.Redirect_PC), 64'h88);
        end
        5: begin
          chk("t5_ras_call", 64'(bus.RAS_CALL_Inst), 64'h1);
          chk("t5_next_pc", 64'(bus.RAS_CALL_Inst_nextPC), 64'h304);
          chk("t5_btb_type", 64'(bus.BTB_Write_Data & 32'h3), 64'h1);
        end
        6: begin
          chk("t5_irq_flush", 64'(bus.Flush), 64'h0);
          chk("t5_irq_call", 64'(bus.RAS_CALL_Inst), 64'h1);
          chk("t5_irq_mcnt", 64'(bus.Mispredict_Count), 64'h5);
        end
        8: chk("blocked_pht_en", 64'(bus.PHT_Write_En), 64'h0);
        9: chk("accepted_pht_en", 64'(bus.PHT_Write_En), 64'h1);
        10: begin
          chk("rst_bcnt", 64'(bus.Branch_Count), 64'h0);
          chk("rst_flush", 64'(bus.Flush), 64'h0);
          chk("rst_redirect", 64'(bus.Redirect_PC), 64'h0);
          chk("rst_btb_data", 64'(bus.BTB_Write_Data), 64'h0);
        end
        11: begin
          chk("reset_flush", 64'(bus.Flush), 64'h0);
          chk("reset_mcnt", 64'(bus.Mispredict_Count), 64'h0);
        end
        12: chk("flush_pulse", 64'(bus.Flush), 64'h1);
        default: ;
      endcase
    end
  end

  // Advance one cycle; the tag names the literal check for the previous vector's outputs.
  task automatic next(input int tag);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    bus.EX_Valid = 1'b0; bus.Stall = 1'b0; bus.IRQ = 1'b0; bus.EX_Is_Call = 1'b0;
    pin_tag = tag;
  endtask

  task automatic ex(input logic [1:0] ty, input logic call, input logic [31:0] pc,
                    input logic at, input logic [31:0] atgt, input logic pt,
                    input logic [31:0] ptgt, input logic hit, input logic [1:0] ctr);
    bus.EX_Valid = 1'b1; bus.EX_Type = ty; bus.EX_Is_Call = call; bus.EX_PC = pc;
    bus.EX_Actual_Taken = at; bus.EX_Actual_Target = atgt; bus.EX_Pred_Taken = pt;
    bus.EX_Pred_Target = ptgt; bus.EX_BTB_Hit = hit; bus.EX_PHT_Counter = ctr;
    bus.EX_PHT_Index = pc[12:2];
  endtask

  initial begin
    bus.Stall = 0; bus.IRQ = 0; bus.EX_Valid = 0; bus.EX_Type = 0; bus.EX_Is_Call = 0;
    bus.EX_PC = 0; bus.EX_Actual_Taken = 0; bus.EX_Actual_Target = 0; bus.EX_Pred_Taken = 0;
    bus.EX_Pred_Target = 0; bus.EX_BTB_Hit = 0; bus.EX_PHT_Index = 0; bus.EX_PHT_Counter = 0;
    repeat (2) @(posedge CLK);
    next(11);
    ex(2'd0, 0, 32'h100, 1, 32'h140, 0, 32'h0, 0, 2'b01);      // T1
    next(1); next(0); next(0);
    ex(2'd0, 0, 32'h104, 1, 32'h180, 1, 32'h180, 1, 2'b11);    // T2
    next(2);
    ex(2'd3, 0, 32'h200, 1, 32'h88, 0, 32'h0, 0, 2'b00);       // T3 RET
    next(3); ex(2'd0, 0, 32'h210, 0, 32'h0, 0, 32'h0, 0, 2'b01);
    next(8); ex(2'd0, 0, 32'h210, 0, 32'h0, 0, 32'h0, 0, 2'b01);
    next(8); ex(2'd0, 0, 32'h210, 0, 32'h0, 0, 32'h0, 0, 2'b01);
    next(9);
    ex(2'd0, 0, 32'h220, 0, 32'h0, 1, 32'h300, 1, 2'b10);      // mispredict, then stall in window
    next(12); ex(2'd0, 0, 32'h224, 1, 32'h230, 1, 32'h230, 1, 2'b10);
    next(8);  ex(2'd0, 0, 32'h224, 1, 32'h230, 1, 32'h230, 1, 2'b10); bus.Stall = 1'b1;
    next(8);  ex(2'd0, 0, 32'h224, 1, 32'h230, 1, 32'h230, 1, 2'b10);
    next(8);  ex(2'd0, 0, 32'h224, 1, 32'h230, 1, 32'h230, 1, 2'b10);
    next(9);
    ex(2'd1, 1, 32'h300, 1, 32'h400, 0, 32'h0, 0, 2'b00);      // JAL call
    next(5); next(0); next(0);
    ex(2'd1, 1, 32'h300, 1, 32'h400, 0, 32'h0, 0, 2'b00); bus.IRQ = 1'b1;
    next(6); ex(2'd0, 0, 32'h308, 0, 32'h0, 0, 32'h0, 0, 2'b00);
    next(9); ex(2'd0, 0, 32'h30C, 1, 32'h500, 1, 32'h500, 1, 2'b01); bus.Stall = 1'b1;
    next(8); ex(2'd0, 0, 32'h100, 1, 32'h140, 0, 32'h0, 0, 2'b01);
    next(12); ex(2'd0, 0, 32'h104, 0, 32'h0, 0, 32'h0, 0, 2'b00); RST = 1'b1;
    next(10); ex(2'd0, 0, 32'h104, 0, 32'h0, 0, 32'h0, 0, 2'b00);
    next(9);
    next(0);
    @(posedge CLK); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end
endmodule
